// File: rtl/piso_serializer_pkg.sv
// Shared types and helpers for the parallel-in/serial-out feeder and the
// serial-side blocks that consume its stream.
package piso_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Width of a words-minus-one length field for a given maximum depth.
  function automatic int len_width(input int depth);
    return $clog2(depth);
  endfunction

  // Bit offset of word idx inside a packed bus of width-bit words.
  function automatic int word_lsb(input int idx, input int width);
    return idx * width;
  endfunction

  localparam int DEFAULT_DATA_WIDTH  = 8;
  localparam int DEFAULT_SHIFT_DEPTH = 16;
  localparam int DEFAULT_LW          = len_width(DEFAULT_SHIFT_DEPTH);

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out feeder: accepts one vector of up to SHIFT_DEPTH words
// per handshake and emits it word 0 first on a valid/ready stream. A one-entry
// pending buffer lets back-to-back vectors stream without a bubble.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter  int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter  int SHIFT_DEPTH = DEFAULT_SHIFT_DEPTH,
  localparam int LW          = len_width(SHIFT_DEPTH),
  localparam int VW          = DATA_WIDTH * SHIFT_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [VW-1:0]         load_data,
  input  logic [LW-1:0]         load_len,
  output logic [DATA_WIDTH-1:0] serial_out,
  output logic                  serial_valid,
  input  logic                  serial_ready,
  output logic                  serial_last,
  output logic                  busy
);

  state_e          state;
  logic [VW-1:0]   act_data;
  logic [LW-1:0]   act_cnt;
  logic [VW-1:0]   pend_data;
  logic [LW-1:0]   pend_cnt;
  logic            pend_v;

  logic            ser_fire;
  logic            last_fire;
  logic            load_fire;

  // Outputs decode straight from registers; load_ready never sees serial_ready.
  assign load_ready   = !pend_v;
  assign serial_valid = (state == SHIFT);
  assign serial_out   = act_data[word_lsb(0, DATA_WIDTH) +: DATA_WIDTH];
  assign serial_last  = serial_valid && (act_cnt == '0);
  assign busy         = (state == SHIFT) || pend_v;

  assign ser_fire  = serial_valid && serial_ready;
  assign last_fire = ser_fire && (act_cnt == '0);
  assign load_fire = load_valid && load_ready;

  // Active/pending vector registers and the IDLE/SHIFT state machine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data registers are reset too, so serial_out reads 0 in reset
      // and nothing from an interrupted vector can leak out after release.
      state     <= IDLE;
      act_data  <= '0;
      act_cnt   <= '0;
      pend_data <= '0;
      pend_cnt  <= '0;
      pend_v    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every branch below sees the
      // pre-edge values of state, count and pend_v.
      case (state)
        IDLE: begin
          if (load_fire) begin
            act_data <= load_data;
            act_cnt  <= load_len;
            state    <= SHIFT;
          end
        end

        SHIFT: begin
          if (last_fire) begin
            if (pend_v) begin
              // Pending vector takes over with no idle cycle in between.
              act_data <= pend_data;
              act_cnt  <= pend_cnt;
              pend_v   <= 1'b0;
            end else if (load_fire) begin
              act_data <= load_data;
              act_cnt  <= load_len;
            end else begin
              state <= IDLE;
            end
          end else begin
            if (ser_fire) begin
              act_data <= {{DATA_WIDTH{1'b0}}, act_data[VW-1:DATA_WIDTH]};
              act_cnt  <= act_cnt - LW'(1);
            end
            if (load_fire) begin
              pend_data <= load_data;
              pend_cnt  <= load_len;
              pend_v    <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: directed scenarios plus random
// traffic, all compared against a queue-based model of the word stream.
module tb_piso_serializer;
  import piso_serializer_pkg::*;

  localparam int DW = 8;
  localparam int SD = 16;
  localparam int LW = 4;
  localparam int VW = DW * SD;

  logic          clk;
  logic          rst_n;
  logic          load_valid;
  logic          load_ready;
  logic [VW-1:0] load_data;
  logic [LW-1:0] load_len;
  logic [DW-1:0] serial_out;
  logic          serial_valid;
  logic          serial_ready;
  logic          serial_last;
  logic          busy;

  piso_serializer #(.DATA_WIDTH(DW), .SHIFT_DEPTH(SD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_data    (load_data),
    .load_len     (load_len),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .serial_ready (serial_ready),
    .serial_last  (serial_last),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: words still owed, in emission order, and the number of
  // words left in each held vector (front = active, second = pending).
  logic [DW-1:0] exp_words[$];
  int            vec_rem[$];

  // Downstream 16-deep free-running delay line fed from serial_out.
  logic [DW-1:0] shreg[SD];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] mk_vec(input logic [DW-1:0] base, input int len);
    logic [VW-1:0] v;
    for (int i = 0; i < SD; i++)
      v[i*DW +: DW] = (i <= len) ? DW'(base + DW'(i)) : DW'($urandom);
    return v;
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, serial_valid, 0);
    check({tag, "_last"},  serial_last,  0);
    check({tag, "_out"},   serial_out,   0);
    check({tag, "_busy"},  busy,         0);
    check({tag, "_ready"}, load_ready,   1);
  endtask

  // One clock: drive inputs, check outputs at the falling edge, then advance
  // the model on the rising edge.
  task automatic cycle(input logic lv, input logic [VW-1:0] ld,
                       input logic [LW-1:0] ll, input logic sr);
    int            n;
    logic          acc_l;
    logic          fire_s;
    logic [DW-1:0] so;
    load_valid   = lv;
    load_data    = ld;
    load_len     = ll;
    serial_ready = sr;
    @(negedge clk);
    n = vec_rem.size();
    check("valid", serial_valid, (n > 0) ? 1 : 0);
    check("ready", load_ready,   (n < 2) ? 1 : 0);
    check("busy",  busy,         (n > 0) ? 1 : 0);
    if (n > 0) begin
      check("out",  serial_out,  exp_words[0]);
      check("last", serial_last, (vec_rem[0] == 1) ? 1 : 0);
    end else begin
      check("last", serial_last, 0);
    end
    so     = serial_out;
    acc_l  = lv && (n < 2);
    fire_s = sr && (n > 0);
    @(posedge clk);
    if (fire_s) begin
      void'(exp_words.pop_front());
      vec_rem[0] = vec_rem[0] - 1;
      if (vec_rem[0] == 0) void'(vec_rem.pop_front());
    end
    if (acc_l) begin
      for (int i = 0; i <= int'(ll); i++) exp_words.push_back(ld[i*DW +: DW]);
      vec_rem.push_back(int'(ll) + 1);
    end
    for (int i = SD - 1; i > 0; i--) shreg[i] = shreg[i-1];
    shreg[0] = so;
    #1;
  endtask

  task automatic idle(input int cycles, input logic sr);
    for (int i = 0; i < cycles; i++) cycle(1'b0, '0, '0, sr);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && vec_rem.size() > 0; i++) cycle(1'b0, '0, '0, 1'b1);
    check("drain_timeout", vec_rem.size(), 0);
  endtask

  initial begin
    rst_n        = 1'b0;
    load_valid   = 1'b0;
    load_data    = '0;
    load_len     = '0;
    serial_ready = 1'b0;
    for (int i = 0; i < SD; i++) shreg[i] = 8'hff;

    repeat (2) @(posedge clk);
    #1;
    check_reset_state("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(2, 1'b1);

    // Plain 4-word vector, downstream always ready.
    cycle(1'b1, mk_vec(8'h10, 3), 4'd3, 1'b1);
    idle(6, 1'b1);

    // Stall for 3 cycles while word 0x11 is presented.
    cycle(1'b1, mk_vec(8'h10, 3), 4'd3, 1'b1);
    cycle(1'b0, '0, '0, 1'b1);
    idle(3, 1'b0);
    idle(5, 1'b1);

    // Back-to-back A then B: B parks in pending, then streams with no gap.
    cycle(1'b1, mk_vec(8'hA0, 3), 4'd3, 1'b1);
    cycle(1'b1, mk_vec(8'hB0, 1), 4'd1, 1'b1);
    idle(8, 1'b1);

    // Boundary lengths.
    cycle(1'b1, mk_vec(8'h50, 0), 4'd0, 1'b1);
    idle(3, 1'b1);
    cycle(1'b1, mk_vec(8'h60, 15), 4'd15, 1'b1);
    idle(18, 1'b1);

    // Load lands on the last-word cycle with nothing pending: zero bubble.
    cycle(1'b1, mk_vec(8'hC0, 1), 4'd1, 1'b1);
    cycle(1'b0, '0, '0, 1'b1);
    cycle(1'b1, mk_vec(8'hD0, 2), 4'd2, 1'b1);
    idle(5, 1'b1);

    // Reset in the middle of a vector discards everything.
    cycle(1'b1, mk_vec(8'h10, 3), 4'd3, 1'b1);
    cycle(1'b0, '0, '0, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_state("mid_rst");
    exp_words.delete();
    vec_rem.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(5, 1'b1);

    // Loopback into a 16-deep delay line: word 0 exits 16 cycles later.
    cycle(1'b1, mk_vec(8'h00, 15), 4'd15, 1'b1);
    for (int j = 0; j < 31; j++) begin
      cycle(1'b0, '0, '0, 1'b1);
      if (j == 15) check("loop_w0",  shreg[SD-1], 8'h00);
      if (j == 30) check("loop_w15", shreg[SD-1], 8'h0F);
    end
    idle(2, 1'b1);

    // Random traffic with random lengths, filler words and backpressure.
    for (int i = 0; i < 1500; i++) begin
      logic [LW-1:0] len;
      len = LW'($urandom_range(0, SD - 1));
      cycle(($urandom_range(0, 2) == 0), mk_vec(DW'($urandom), int'(len)), len,
            ($urandom_range(0, 3) != 0));
    end
    drain();
    idle(2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
